// File: rtl/wb3_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb3_rr_arbiter: two-master round-robin Wishbone B3 arbiter with watchdog |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module wb3_rr_arbiter #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  input  logic                  m0_we,
  input  logic                  m0_stb,
  input  logic                  m0_cyc,
  output logic                  m0_ack,
  output logic                  m0_err,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  input  logic                  m1_we,
  input  logic                  m1_stb,
  input  logic                  m1_cyc,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  output logic                  s_we,
  output logic                  s_stb,
  output logic                  s_cyc,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack,
  output logic [1:0]            gnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // The current stalled cycle counts itself, so the hit is one below TIMEOUT.
  localparam logic [7:0] C_WDOG_HIT = 8'(TIMEOUT - 1);

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_gnt, w_gnt_nxt;
  logic                  r_last, w_last_nxt;
  logic [7:0]            r_wdog, w_wdog_nxt;
  logic                  w_err;

  logic                  w_own1;
  logic                  w_pick1;
  logic                  w_o_cyc;
  logic                  w_o_stb;
  logic                  w_o_we;
  logic [ADDR_WIDTH-1:0] w_o_addr;
  logic [DATA_WIDTH-1:0] w_o_dat;

  assign w_own1   = r_gnt[1];
  assign w_o_cyc  = w_own1 ? m1_cyc   : m0_cyc;
  assign w_o_stb  = w_own1 ? m1_stb   : m0_stb;
  assign w_o_we   = w_own1 ? m1_we    : m0_we;
  assign w_o_addr = w_own1 ? m1_addr  : m0_addr;
  assign w_o_dat  = w_own1 ? m1_dat_i : m0_dat_i;

  // On a tie the master that did not win last time is chosen.
  assign w_pick1  = m1_cyc & (~m0_cyc | ~r_last);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state <= S_IDLE;
      r_gnt   <= 2'b00;
      r_last  <= 1'b1;
      r_wdog  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
      r_wdog  <= w_wdog_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    w_wdog_nxt  = 8'd0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (m0_cyc || m1_cyc) begin
          w_state_nxt = S_OWN;
          w_gnt_nxt   = w_pick1 ? 2'b10 : 2'b01;
          w_last_nxt  = w_pick1;
        end
      end
      S_OWN: begin
        if (!w_o_cyc) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = 2'b00;
        end else if (w_o_stb && !s_ack) begin
          if (r_wdog == C_WDOG_HIT) begin
            w_err       = 1'b1;
            w_state_nxt = S_DRAIN;
          end else begin
            w_wdog_nxt = r_wdog + 8'd1;
          end
        end
      end
      S_DRAIN: begin
        if (!w_o_cyc) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = 2'b00;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 2'b00;
      end
    endcase
  end

  always_comb begin
    s_addr   = '0;
    s_dat_o  = '0;
    s_we     = 1'b0;
    s_stb    = 1'b0;
    s_cyc    = 1'b0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_dat_o = '0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_dat_o = '0;
    if (r_state == S_OWN && w_o_cyc) begin
      s_addr  = w_o_addr;
      s_dat_o = w_o_dat;
      s_we    = w_o_we;
      s_stb   = w_o_stb;
      s_cyc   = 1'b1;
      if (w_own1) begin
        m1_ack   = s_ack;
        m1_err   = w_err;
        m1_dat_o = s_dat_i;
      end else begin
        m0_ack   = s_ack;
        m0_err   = w_err;
        m0_dat_o = s_dat_i;
      end
    end
  end

  assign gnt = r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_wb3_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb3_rr_arbiter: directed self-checking bench for wb3_rr_arbiter       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_wb3_rr_arbiter;

  logic       clk = 1'b0;
  logic       arst = 1'b0;
  logic [2:0] m0_addr = '0, m1_addr = '0, s_addr;
  logic [7:0] m0_dat_i = '0, m1_dat_i = '0, m0_dat_o, m1_dat_o, s_dat_o;
  logic       m0_we = 0, m0_stb = 0, m0_cyc = 0, m0_ack, m0_err;
  logic       m1_we = 0, m1_stb = 0, m1_cyc = 0, m1_ack, m1_err;
  logic       s_we, s_stb, s_cyc, s_ack;
  logic [7:0] s_dat_i = '0;
  logic [1:0] gnt;
  logic       auto_ack = 1'b0, man_ack = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  // Slave model: either acks every strobe in the same cycle, or a manual level.
  assign s_ack = auto_ack ? s_stb : man_ack;

  always #5 clk = ~clk;

  wb3_rr_arbiter #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .TIMEOUT(8)) dut (
    .clk(clk), .arst(arst),
    .m0_addr(m0_addr), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we(m0_we),
    .m0_stb(m0_stb), .m0_cyc(m0_cyc), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we(m1_we),
    .m1_stb(m1_stb), .m1_cyc(m1_cyc), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_addr(s_addr), .s_dat_o(s_dat_o), .s_we(s_we), .s_stb(s_stb), .s_cyc(s_cyc),
    .s_dat_i(s_dat_i), .s_ack(s_ack), .gnt(gnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change 1 ns after the rising edge; checks run 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_m0(input logic cyc, input logic stb, input logic we,
                        input logic [2:0] addr, input logic [7:0] dat);
    m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_addr = addr; m0_dat_i = dat;
  endtask

  task automatic set_m1(input logic cyc, input logic stb, input logic we,
                        input logic [2:0] addr, input logic [7:0] dat);
    m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_addr = addr; m1_dat_i = dat;
  endtask

  task automatic do_reset();
    arst = 1'b0;
    tick();
    arst = 1'b1;
  endtask

  initial begin
    // Reset state, with stimulus present that would otherwise reach the outputs
    set_m0(1, 1, 1, 3'd5, 8'hAA);
    man_ack = 1'b1;
    s_dat_i = 8'h77;
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_s_cyc", 32'(s_cyc), 32'h0);
    chk("rst_s_stb", 32'(s_stb), 32'h0);
    chk("rst_s_addr", 32'(s_addr), 32'h0);
    chk("rst_m0_ack", 32'(m0_ack), 32'h0);
    chk("rst_m0_dat_o", 32'(m0_dat_o), 32'h0);
    set_m0(0, 0, 0, 3'd0, 8'h00);
    man_ack = 1'b0;
    s_dat_i = 8'h00;
    arst = 1'b1;
    tick();

    // Single write, slave acks one cycle after stb
    set_m0(1, 1, 1, 3'd3, 8'h5A);
    settle();
    chk("wr_req_gnt", 32'(gnt), 32'h0);
    tick();
    chk("wr_gnt", 32'(gnt), 32'h1);
    chk("wr_s_cyc", 32'(s_cyc), 32'h1);
    chk("wr_s_addr", 32'(s_addr), 32'h3);
    chk("wr_s_dat_o", 32'(s_dat_o), 32'h5A);
    chk("wr_s_we", 32'(s_we), 32'h1);
    chk("wr_ack_early", 32'(m0_ack), 32'h0);
    tick();
    man_ack = 1'b1;
    settle();
    chk("wr_m0_ack", 32'(m0_ack), 32'h1);
    chk("wr_m1_ack", 32'(m1_ack), 32'h0);
    tick();
    man_ack = 1'b0;
    set_m0(0, 0, 0, 3'd0, 8'h00);
    settle();
    chk("wr_drop_s_cyc", 32'(s_cyc), 32'h0);
    chk("wr_drop_ack", 32'(m0_ack), 32'h0);
    tick();
    chk("wr_gnt_idle", 32'(gnt), 32'h0);

    // Simultaneous single reads straight after reset
    do_reset();
    auto_ack = 1'b1;
    set_m0(1, 1, 0, 3'd1, 8'h00);
    set_m1(1, 1, 0, 3'd2, 8'h00);
    s_dat_i = 8'h3C;
    tick();
    chk("sim_gnt_m0", 32'(gnt), 32'h1);
    chk("sim_s_addr_m0", 32'(s_addr), 32'h1);
    chk("sim_m0_ack", 32'(m0_ack), 32'h1);
    chk("sim_m0_dat", 32'(m0_dat_o), 32'h3C);
    chk("sim_m1_ack_wait", 32'(m1_ack), 32'h0);
    chk("sim_m1_dat_wait", 32'(m1_dat_o), 32'h0);
    tick();
    set_m0(0, 0, 0, 3'd0, 8'h00);
    settle();
    chk("sim_k_s_cyc", 32'(s_cyc), 32'h0);
    tick();
    chk("sim_k1_gnt", 32'(gnt), 32'h0);
    chk("sim_k1_s_cyc", 32'(s_cyc), 32'h0);
    s_dat_i = 8'hC3;
    tick();
    chk("sim_k2_gnt", 32'(gnt), 32'h2);
    chk("sim_k2_s_cyc", 32'(s_cyc), 32'h1);
    chk("sim_k2_s_addr", 32'(s_addr), 32'h2);
    chk("sim_m1_ack", 32'(m1_ack), 32'h1);
    chk("sim_m1_dat", 32'(m1_dat_o), 32'hC3);
    chk("sim_m0_ack_off", 32'(m0_ack), 32'h0);
    tick();
    set_m1(0, 0, 0, 3'd0, 8'h00);
    tick();

    // Fairness: both request again right after every single transfer
    for (int i = 0; i < 6; i++) begin
      set_m0(1, 1, 0, 3'd4, 8'h00);
      set_m1(1, 1, 0, 3'd6, 8'h00);
      tick();
      chk($sformatf("fair_gnt%0d", i), 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      if (gnt[1]) set_m1(0, 0, 0, 3'd0, 8'h00);
      else        set_m0(0, 0, 0, 3'd0, 8'h00);
      tick();
    end
    set_m0(0, 0, 0, 3'd0, 8'h00);
    set_m1(0, 0, 0, 3'd0, 8'h00);
    tick();

    // Atomic burst: m1 holds cyc for 4 beats, m0 joins from beat 1
    set_m1(1, 1, 1, 3'd7, 8'h11);
    tick();
    set_m0(1, 1, 0, 3'd2, 8'h00);
    for (int b = 0; b < 4; b++) begin
      settle();
      chk($sformatf("bur_gnt%0d", b), 32'(gnt), 32'h2);
      chk($sformatf("bur_m1_ack%0d", b), 32'(m1_ack), 32'h1);
      chk($sformatf("bur_m0_ack%0d", b), 32'(m0_ack), 32'h0);
      tick();
    end
    set_m1(0, 0, 0, 3'd0, 8'h00);
    settle();
    chk("bur_drop_m0_ack", 32'(m0_ack), 32'h0);
    tick();
    chk("bur_idle_gnt", 32'(gnt), 32'h0);
    tick();
    chk("bur_m0_gnt", 32'(gnt), 32'h1);
    chk("bur_m0_ack", 32'(m0_ack), 32'h1);
    tick();
    set_m0(0, 0, 0, 3'd0, 8'h00);
    tick();

    // Watchdog with TIMEOUT=8: slave never acks
    auto_ack = 1'b0;
    man_ack  = 1'b0;
    set_m0(1, 1, 0, 3'd1, 8'h00);
    tick();
    for (int c = 1; c <= 9; c++) begin
      if (c == 7) chk("wd_err_c7", 32'(m0_err), 32'h0);
      if (c == 8) begin
        chk("wd_err_c8", 32'(m0_err), 32'h1);
        chk("wd_stb_c8", 32'(s_stb), 32'h1);
        chk("wd_m1_err_c8", 32'(m1_err), 32'h0);
      end
      if (c == 9) begin
        man_ack = 1'b1;
        settle();
        chk("wd_err_c9", 32'(m0_err), 32'h0);
        chk("wd_stb_c9", 32'(s_stb), 32'h0);
        chk("wd_cyc_c9", 32'(s_cyc), 32'h0);
        chk("wd_drain_ack", 32'(m0_ack), 32'h0);
        chk("wd_drain_gnt", 32'(gnt), 32'h1);
      end
      tick();
    end
    man_ack = 1'b0;
    settle();
    chk("wd_hold_gnt", 32'(gnt), 32'h1);
    set_m0(0, 0, 0, 3'd0, 8'h00);
    tick();
    chk("wd_idle_gnt", 32'(gnt), 32'h0);

    // Asynchronous reset during m1 ownership
    auto_ack = 1'b1;
    set_m1(1, 1, 0, 3'd5, 8'h00);
    tick();
    chk("ar_pre_gnt", 32'(gnt), 32'h2);
    chk("ar_pre_m1_ack", 32'(m1_ack), 32'h1);
    #2;
    arst = 1'b0;
    #1;
    chk("ar_s_cyc", 32'(s_cyc), 32'h0);
    chk("ar_s_stb", 32'(s_stb), 32'h0);
    chk("ar_m1_ack", 32'(m1_ack), 32'h0);
    chk("ar_gnt", 32'(gnt), 32'h0);
    tick();
    arst = 1'b1;
    set_m1(0, 0, 0, 3'd0, 8'h00);
    tick();
    set_m0(1, 1, 0, 3'd0, 8'h00);
    set_m1(1, 1, 0, 3'd0, 8'h00);
    tick();
    chk("ar_first_gnt", 32'(gnt), 32'h1);
    set_m0(0, 0, 0, 3'd0, 8'h00);
    set_m1(0, 0, 0, 3'd0, 8'h00);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb3_rr_arbiter.md
# wb3_rr_arbiter

Two-port round-robin arbiter that shares the single Wishbone B3 slave port of the I2C master core between two bus masters (e.g. a CPU-side master and an autonomous register sequencer). It grants ownership of the whole `cyc` cycle to one master and muxes address, data and control to the slave. It routes `ack` back to the owner only, and terminates hung cycles with a watchdog `err`.

## Interface
- `ADDR_WIDTH`, default 3: Wishbone address width.
- `DATA_WIDTH`, default 8: Wishbone data width.
- `TIMEOUT`, default 255: number of `stb`-high cycles without `ack` before the watchdog fires (1..255).
- `clk`  in  1  system clock; all logic on rising edge.
- `arst`  in  1  asynchronous, active-low reset.
- `m0_addr`/`m1_addr`  in  ADDR_WIDTH  master address.
- `m0_dat_i`/`m1_dat_i`  in  DATA_WIDTH  master write data.
- `m0_dat_o`/`m1_dat_o`  out  DATA_WIDTH  read data returned to master.
- `m0_we`/`m1_we`, `m0_stb`/`m1_stb`, `m0_cyc`/`m1_cyc`  in  1  master control.
- `m0_ack`/`m1_ack`  out  1  cycle acknowledge to master.
- `m0_err`/`m1_err`  out  1  watchdog error, one-cycle pulse.
- `s_addr`  out  ADDR_WIDTH; `s_dat_o`  out  DATA_WIDTH (write data to slave); `s_we`, `s_stb`, `s_cyc`  out  1.
- `s_dat_i`  in  DATA_WIDTH  slave read data; `s_ack`  in  1  slave acknowledge.
- `gnt`  out  2  one-hot current owner (00 = none), for debug.

## Operation
- States: IDLE, OWN, DRAIN. A registered `last` bit records the most recently granted master.
- Reset: state IDLE, `gnt`=00, `last`=1 (m0 wins first contest), watchdog counter 0. All `s_*` outputs, `m*_ack`, `m*_err` and `m*_dat_o` are 0.
- IDLE: requests are `m0_cyc` and `m1_cyc`.
  - A single request is granted.
  - If both request, the master ≠ `last` is granted.
  - On grant: go to OWN, set `gnt`, set `last` to the granted index.
  - No request: stay in IDLE.
- OWN: `s_addr`, `s_dat_o`, `s_we`, `s_stb`, `s_cyc` are combinationally driven from the owner.
  - Owner's `ack` = `s_ack`. Owner's `dat_o` = `s_dat_i`.
  - Non-owner's `ack`, `err` and `dat_o` are 0.
  - Grant is held for the full `cyc` (multi-beat and read-modify-write sequences stay atomic).
  - Owner `cyc` low: `s_*` go low that same cycle; next state IDLE, `gnt`=00.
- Watchdog: the counter increments each OWN cycle with `s_stb`=1 and `s_ack`=0. It clears on `s_ack`, on leaving OWN, and when `stb` is low.
  - When the counter reaches `TIMEOUT`, the owner's `err` pulses for exactly one cycle and state goes to DRAIN.
- DRAIN: `s_cyc`/`s_stb` forced low and `s_ack` ignored. The state is held until the owner drops `cyc`, then goes to IDLE.
- Idle bus: `s_*` outputs are 0 whenever `gnt`=00.
- A non-owner asserting `cyc` waits; it receives no `ack` or `err` until granted.

## Timing
- Arbitration latency: 1 cycle. A request is seen in cycle N, `gnt` is registered at the end of N, and `s_cyc`/`s_stb` are high in N+1.
- `ack` path: combinational, zero cycles from `s_ack` to the owner's `ack`. A single-beat transfer with a same-cycle slave ack completes in N+1.
- Back-to-back: owner drops `cyc` in cycle K. The other pending master is granted at the end of K+1 (IDLE occupies K+1) and drives the slave in K+2.
- `err` is asserted in the cycle where the counter equals `TIMEOUT`; `s_stb` is low from the following cycle.
- `arst` asserted mid-cycle: all outputs go to reset values immediately (asynchronous). After release, the first grant goes to m0.

## Test plan
- Single write: m0 writes `addr`=3, `dat`=0x5A, with slave ack one cycle after `stb`. Expect `s_addr`=3, `s_dat_o`=0x5A, `s_we`=1, `m0_ack` for one cycle, `m1_ack`=0, `gnt` 01→00.
- Simultaneous request after reset: m0 and m1 both raise `cyc` in the same cycle for single reads. Expect m0 served first, m1 granted next, with m1 `s_cyc` two cycles after m0 drops `cyc`. `m1_dat_o` equals `s_dat_i` (e.g. 0xC3).
- Fairness: both masters request continuously for 6 cycles of single transfers each. Expect grants alternating m0, m1, m0, m1, m0, m1.
- Atomic burst: m1 holds `cyc` for 4 acked beats while m0 requests from beat 1. Expect m0 not granted until m1 drops `cyc`, and `m0_ack`=0 throughout.
- Watchdog: `TIMEOUT`=8, m0 `stb` high, slave never acks. Expect `m0_err` pulse on the 8th cycle, `s_stb` low afterwards, and IDLE once m0 drops `cyc`.
- Reset mid-transfer: assert `arst` low during m1 ownership. Expect `s_cyc`, `s_stb`, `m1_ack` and `gnt` at 0 immediately. After release, simultaneous requests grant m0.
